round_recorder: RTL and testbench
=================================

// Module: round_recorder
// PURPOSE
//  Builds the 10-bit round-result vector Out_cr that the winner-decision logic consumes.
//  Bit [2k] = player 1 took round k; bit [2k+1] = player 2 took round k.
//  Accepts one round result per valid/ready handshake from the game controller.
//  Raises Out_done once the match vector is final, then holds it stable for scoring.
// PARAMETERS
//  ROUNDS      5   rounds per match; Out_cr width = 2*ROUNDS
//  CNT_W       3   width of round index; must satisfy 2**CNT_W > ROUNDS
// PORTS
//  Clock       in   1         rising-edge clock
//  Reset_n     in   1         async active-low reset
//  In_start    in   1         pulse: clear vector, begin a new match
//  In_valid    in   1         round result present on In_p1/In_p2
//  In_p1       in   1         player 1 took this round
//  In_p2       in   1         player 2 took this round (both=1 is a shared round)
//  Out_ready   out  1         recorder accepts a result this cycle
//  Out_cr      out  2*ROUNDS  round-result vector
//  Out_round   out  CNT_W     rounds recorded so far, 0..ROUNDS
//  Out_done    out  1         match complete; Out_cr final
// BEHAVIOUR
//  - Reset (async, Reset_n=0): state IDLE, Out_cr=0, Out_round=0, Out_ready=0, Out_done=0.
//  - FSM: IDLE -(In_start)-> COLLECT -(last accept)-> DONE -(In_start)-> COLLECT.
//  - In_start in any state: on the next edge, Out_cr=0, Out_round=0, Out_done=0 -> COLLECT.
//    In_start has priority over a same-cycle In_valid; that result is dropped.
//  - COLLECT: Out_ready=1. Accept when In_valid & Out_ready at the edge.
//    On accept, Out_cr[2*Out_round]<=In_p1, Out_cr[2*Out_round+1]<=In_p2, Out_round++.
//  - Latency: each bit appears on Out_cr one cycle after acceptance.
//    Out_done rises in the same edge as the ROUNDS-th accept.
//  - In_p1=In_p2=0 is legal: void round, both bits 0, index still advances.
//  - DONE and IDLE: Out_ready=0. In_valid is ignored; no overflow and no wrap of Out_round.
//  - Out_cr, Out_round and Out_done are registered. Out_ready is decoded from state only.
//  - Reset asserted mid-match discards partial results immediately.
// CONFIGURATION
//  EARLY_DECIDE_EN defined:
//   - Running p1/p2 tallies are kept, width CNT_W.
//   - After an accept, if the lead exceeds the remaining rounds, go to DONE with Out_done=1.
//   - Unplayed bits stay 0, so the winner decision is unchanged.
//  EARLY_DECIDE_EN undefined: the full ROUNDS are always collected; no tally logic.
// STRUCTURE
//  - Shared include game_defs.vh holds:
//    - state encodings ST_IDLE=2'd0, ST_COLLECT=2'd1, ST_DONE=2'd2;
//    - the default ROUNDS value;
//    - the result codes 01/10/11 used by the winner-decision logic.
//  - One sub-module, round_tally (p1/p2 counters plus lead compare).
//    It is instantiated only under EARLY_DECIDE_EN.
// TESTING
//  1. Reset, start, then 5 accepts (p1,p2) = 10,01,10,11,00.
//     -> Out_cr=10'b00_11_01_10_01, Out_round=5, Out_done=1 after the 5th edge.
//  2. In DONE, drive In_valid=1 for 3 cycles.
//     -> Out_ready=0 throughout; Out_cr and Out_round unchanged.
//  3. After 2 accepts, assert In_start together with In_valid.
//     -> Out_cr=0, Out_round=0, state COLLECT; the concurrent result is not recorded.
//  4. Pull Reset_n low between clock edges mid-match.
//     -> all outputs go to 0 without waiting for a clock edge; IDLE holds until In_start.
//  5. EARLY_DECIDE_EN: accepts 10,10,10.
//     -> Out_done=1 at the 3rd accept; Out_cr=10'b00_00_01_01_01; Out_round=3.
//  6. No EARLY_DECIDE_EN: same stimulus as 5.
//     -> Out_done stays 0 and Out_ready stays 1 until 2 more accepts.

Source files
------------

// File: rtl/round_recorder_pkg.sv
// Shared definitions for the round recorder: FSM encodings, default match length,
// and the 2-bit per-round result codes read by the winner-decision logic.
package round_recorder_pkg;

    localparam int ROUNDS_DEF = 5;
    localparam int CNT_W_DEF  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam logic [1:0] RES_P1     = 2'b01;
    localparam logic [1:0] RES_P2     = 2'b10;
    localparam logic [1:0] RES_SHARED = 2'b11;

    // Low bit of the pair is player 1, high bit is player 2.
    function automatic logic [1:0] result_code(input logic p1, input logic p2);
        return {p2, p1};
    endfunction

endpackage

// File: rtl/round_recorder_if.sv
// Handshake and result bus between the game controller (master) and the
// round recorder (slave).
interface round_recorder_if #(
    parameter int ROUNDS = round_recorder_pkg::ROUNDS_DEF,
    parameter int CNT_W  = round_recorder_pkg::CNT_W_DEF
);
    logic                  In_start;
    logic                  In_valid;
    logic                  In_p1;
    logic                  In_p2;
    logic                  Out_ready;
    logic [2*ROUNDS-1:0]   Out_cr;
    logic [CNT_W-1:0]      Out_round;
    logic                  Out_done;

    modport master (
        output In_start, In_valid, In_p1, In_p2,
        input  Out_ready, Out_cr, Out_round, Out_done
    );

    modport slave (
        input  In_start, In_valid, In_p1, In_p2,
        output Out_ready, Out_cr, Out_round, Out_done
    );
endinterface

// File: rtl/round_recorder_tally.sv
// round_tally: running per-player round counts and the "match already decided"
// compare. Only instantiated when EARLY_DECIDE_EN is defined.
module round_tally #(
    parameter int ROUNDS = 5,
    parameter int CNT_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             accept_i,
    input  logic             p1_i,
    input  logic             p2_i,
    input  logic [CNT_W-1:0] round_next_i,
    output logic             decide_o
);
    localparam logic [CNT_W-1:0] ROUNDS_C = CNT_W'(ROUNDS);

    logic [CNT_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [CNT_W-1:0] p1_nx_s, p2_nx_s, lead_s, remain_s;

    assign p1_nx_s  = p1_q + {{(CNT_W-1){1'b0}}, p1_i};
    assign p2_nx_s  = p2_q + {{(CNT_W-1){1'b0}}, p2_i};
    assign lead_s   = (p1_nx_s >= p2_nx_s) ? (p1_nx_s - p2_nx_s) : (p2_nx_s - p1_nx_s);
    assign remain_s = ROUNDS_C - round_next_i;
    // Decided as if the current result is accepted; the caller gates it with accept.
    assign decide_o = (lead_s > remain_s);

    // Next tally values.
    always_comb begin
        p1_d = p1_q;
        p2_d = p2_q;
        if (clear_i) begin
            p1_d = '0;
            p2_d = '0;
        end else if (accept_i) begin
            p1_d = p1_nx_s;
            p2_d = p2_nx_s;
        end else begin
            p1_d = p1_q;
            p2_d = p2_q;
        end
    end

    // Tally registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_q <= '0;
            p2_q <= '0;
        end else begin
            p1_q <= p1_d;
            p2_q <= p2_d;
        end
    end
endmodule

// File: rtl/round_recorder.sv
// round_recorder: collects one result per round into the match vector Out_cr.
// Optional EARLY_DECIDE_EN ends the match once the lead cannot be overturned.
module round_recorder
    import round_recorder_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic            Clock,
    input  logic            Reset_n,
    round_recorder_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(ROUNDS);

    state_e              state_q, state_d;
    logic [2*ROUNDS-1:0] cr_q, cr_d;
    logic [CNT_W-1:0]    round_q, round_d, round_inc_s;
    logic                done_q, done_d;
    logic                ready_s, accept_s, decide_s;

    assign ready_s     = (state_q == ST_COLLECT);
    assign round_inc_s = round_q + CNT_W'(1);

`ifdef EARLY_DECIDE_EN
    round_tally #(
        .ROUNDS (ROUNDS),
        .CNT_W  (CNT_W)
    ) u_tally (
        .clk          (Clock),
        .rst_n        (Reset_n),
        .clear_i      (bus.In_start),
        .accept_i     (accept_s),
        .p1_i         (bus.In_p1),
        .p2_i         (bus.In_p2),
        .round_next_i (round_inc_s),
        .decide_o     (decide_s)
    );
`else
    assign decide_s = 1'b0;
`endif

    // Next-state and vector update; In_start outranks any same-cycle result.
    always_comb begin
        state_d  = state_q;
        cr_d     = cr_q;
        round_d  = round_q;
        done_d   = done_q;
        accept_s = 1'b0;
        if (bus.In_start) begin
            state_d = ST_COLLECT;
            cr_d    = '0;
            round_d = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (bus.In_valid) begin
                        accept_s = 1'b1;
                        for (int k = 0; k < ROUNDS; k++) begin
                            if (round_q == CNT_W'(k)) begin
                                cr_d[2*k +: 2] = result_code(bus.In_p1, bus.In_p2);
                            end else begin
                                cr_d[2*k +: 2] = cr_q[2*k +: 2];
                            end
                        end
                        round_d = round_inc_s;
                        if ((round_inc_s == LAST_C) || decide_s) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_COLLECT;
                            done_d  = 1'b0;
                        end
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                    cr_d    = '0;
                    round_d = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            cr_q    <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cr_q    <= cr_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign bus.Out_ready = ready_s;
    assign bus.Out_cr    = cr_q;
    assign bus.Out_round = round_q;
    assign bus.Out_done  = done_q;
endmodule

// File: tb/tb_round_recorder.sv
// Self-checking bench for round_recorder: a vector table driven through a scoreboard
// queue, plus hand-written async-reset and early-decide sequences.
module tb_round_recorder;
    import round_recorder_pkg::*;

    typedef struct {
        string      name;
        logic       start;
        logic       valid;
        logic       p1;
        logic       p2;
        logic       exp_ready;
        logic [9:0] exp_cr;
        logic [2:0] exp_round;
        logic       exp_done;
    } vec_t;

    logic Clock;
    logic Reset_n;
    int   total;
    int   bad;
    vec_t tbl[$];
    vec_t sb[$];

    round_recorder_if #(.ROUNDS(5), .CNT_W(3)) bus ();

    round_recorder #(.ROUNDS(5), .CNT_W(3)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic vec_t mk(input string n, input logic s, input logic v,
                                input logic p1, input logic p2, input logic rdy,
                                input logic [9:0] cr, input logic [2:0] rnd, input logic d);
        vec_t r;
        r.name = n; r.start = s; r.valid = v; r.p1 = p1; r.p2 = p2;
        r.exp_ready = rdy; r.exp_cr = cr; r.exp_round = rnd; r.exp_done = d;
        return r;
    endfunction

    task automatic chk(input string n, input logic [9:0] got, input logic [9:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", n, got, want);
        end
    endtask

    task automatic check_outs(input vec_t e);
        chk({e.name, ".ready"}, {9'd0, bus.Out_ready}, {9'd0, e.exp_ready});
        chk({e.name, ".cr"}, bus.Out_cr, e.exp_cr);
        chk({e.name, ".round"}, {7'd0, bus.Out_round}, {7'd0, e.exp_round});
        chk({e.name, ".done"}, {9'd0, bus.Out_done}, {9'd0, e.exp_done});
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input vec_t v);
        vec_t e;
        bus.In_start = v.start;
        bus.In_valid = v.valid;
        bus.In_p1    = v.p1;
        bus.In_p2    = v.p2;
        sb.push_back(v);
        @(posedge Clock);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty got=0 want=1", v.name);
        end else begin
            e = sb.pop_front();
            check_outs(e);
        end
        bus.In_start = 1'b0;
        bus.In_valid = 1'b0;
        bus.In_p1    = 1'b0;
        bus.In_p2    = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.In_start = 1'b0;
        bus.In_valid = 1'b0;
        bus.In_p1    = 1'b0;
        bus.In_p2    = 1'b0;
        Reset_n      = 1'b1;
        #1 Reset_n   = 1'b0;
        #2;
        check_outs(mk("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 3'd0, 1'b0));
        #10 Reset_n  = 1'b1;

        // IDLE ignores results; full match 10,01,10,11,00; DONE ignores results;
        // start with a concurrent result mid-match drops that result.
        tbl.push_back(mk("idle_valid", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 3'd0, 1'b0));
        tbl.push_back(mk("t1_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 3'd0, 1'b0));
        tbl.push_back(mk("t1_r1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b00_00_00_00_01, 3'd1, 1'b0));
        tbl.push_back(mk("t1_r2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'b00_00_00_10_01, 3'd2, 1'b0));
        tbl.push_back(mk("t1_r3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b00_00_01_10_01, 3'd3, 1'b0));
        tbl.push_back(mk("t1_r4", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'b00_11_01_10_01, 3'd4, 1'b0));
        tbl.push_back(mk("t1_r5", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'b00_11_01_10_01, 3'd5, 1'b1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk("t2_done_hold", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'b00_11_01_10_01, 3'd5, 1'b1));
        tbl.push_back(mk("t3_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 3'd0, 1'b0));
        tbl.push_back(mk("t3_r1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b00_00_00_00_01, 3'd1, 1'b0));
        tbl.push_back(mk("t3_r2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'b00_00_00_10_01, 3'd2, 1'b0));
        tbl.push_back(mk("t3_restart", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 3'd0, 1'b0));
        tbl.push_back(mk("t3_after", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'b00_00_00_00_11, 3'd1, 1'b0));
        tbl.push_back(mk("t3_r2b", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'b00_00_00_10_11, 3'd2, 1'b0));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Asynchronous reset mid-match, between clock edges.
        #3 Reset_n = 1'b0;
        #1;
        check_outs(mk("t4_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 3'd0, 1'b0));
        @(posedge Clock);
        #3 Reset_n = 1'b1;
        @(posedge Clock);
        #1;
        step(mk("t4_idle_a", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 3'd0, 1'b0));
        step(mk("t4_idle_b", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 3'd0, 1'b0));
        step(mk("t4_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 3'd0, 1'b0));

        // Three straight player-1 rounds.
        step(mk("t5_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 3'd0, 1'b0));
        step(mk("t5_r1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b00_00_00_00_01, 3'd1, 1'b0));
        step(mk("t5_r2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b00_00_00_01_01, 3'd2, 1'b0));
`ifdef EARLY_DECIDE_EN
        step(mk("t5_r3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'b00_00_01_01_01, 3'd3, 1'b1));
        step(mk("t5_hold", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'b00_00_01_01_01, 3'd3, 1'b1));
`else
        step(mk("t6_r3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b00_00_01_01_01, 3'd3, 1'b0));
        step(mk("t6_r4", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'b00_00_01_01_01, 3'd4, 1'b0));
        step(mk("t6_r5", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'b00_00_01_01_01, 3'd5, 1'b1));
        step(mk("t6_hold", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'b00_00_01_01_01, 3'd5, 1'b1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
